// File: rtl/spi_slave_axi_rx_fifo.sv
// First-word-fall-through receive FIFO between the SPI RX clock crossing and the AXI write engine.
// Tracks occupancy and an almost-full warning, and keeps sticky overflow and drop statistics.
module spi_slave_axi_rx_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = 2
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic                      flush_i,
    input  logic [DATA_WIDTH-1:0]     in_data_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic [DATA_WIDTH-1:0]     out_data_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      almost_full_o,
    output logic                      overflow_o,
    output logic [15:0]               drop_cnt_o,
    input  logic                      ovf_clr_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             almost_full_q, almost_full_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic full, empty, push, pop, drop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign push  = in_valid_i & ~full;
    assign pop   = out_ready_i & ~empty;
    assign drop  = in_valid_i & full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        // Registered flag reflects the occupancy the FIFO will have after this edge.
        almost_full_d = ((DEPTH_C - count_d) <= AF_C);
    end

    // Drops are counted even during flush; a clear in the same cycle wins.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (ovf_clr_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Storage carries no reset; valid entries are defined solely by the pointers and count.
    always_ff @(posedge axi_aclk) begin
        if (push && !flush_i) mem_q[wr_ptr_q] <= in_data_i;
    end

    assign in_ready_o    = ~full;
    assign out_valid_o   = ~empty;
    assign out_data_o    = mem_q[rd_ptr_q];
    assign count_o       = count_q;
    assign almost_full_o = almost_full_q;
    assign overflow_o    = overflow_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_spi_slave_axi_rx_fifo.sv
// Bench for the FWFT receive FIFO: directed scenarios plus random traffic checked every cycle
// against a queue-based reference model.
module tb_spi_slave_axi_rx_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AF    = 2;

    logic          axi_aclk = 1'b0;
    logic          axi_aresetn = 1'b0;
    logic          flush_i = 1'b0;
    logic [DW-1:0] in_data_i = '0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] out_data_o;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [3:0]    count_o;
    logic          almost_full_o;
    logic          overflow_o;
    logic [15:0]   drop_cnt_o;
    logic          ovf_clr_i = 1'b0;

    spi_slave_axi_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
        .axi_aclk      (axi_aclk),
        .axi_aresetn   (axi_aresetn),
        .flush_i       (flush_i),
        .in_data_i     (in_data_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .out_data_o    (out_data_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .count_o       (count_o),
        .almost_full_o (almost_full_o),
        .overflow_o    (overflow_o),
        .drop_cnt_o    (drop_cnt_o),
        .ovf_clr_i     (ovf_clr_i)
    );

    always #5 axi_aclk = ~axi_aclk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: contents as a queue, statistics as plain variables.
    logic [DW-1:0] model_q[$];
    logic          m_ovf = 1'b0;
    int            m_drops = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_state();
        int sz;
        sz = model_q.size();
        check_eq("count",       32'(count_o),       32'(sz));
        check_eq("out_valid",   32'(out_valid_o),   32'(sz > 0));
        check_eq("in_ready",    32'(in_ready_o),    32'(sz < DEPTH));
        check_eq("almost_full", 32'(almost_full_o), 32'((DEPTH - sz) <= AF));
        check_eq("overflow",    32'(overflow_o),    32'(m_ovf));
        check_eq("drop_cnt",    32'(drop_cnt_o),    32'(m_drops));
        if (sz > 0) check_eq("out_data", out_data_o, model_q[0]);
    endtask

    // Called at a falling edge: check, drive, clock, update model, return at next falling edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r,
                         input logic fl, input logic oc);
        bit was_full, was_empty;
        check_state();
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        flush_i     = fl;
        ovf_clr_i   = oc;
        @(posedge axi_aclk);
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        if (fl) begin
            model_q.delete();
        end else begin
            if (r && !was_empty) void'(model_q.pop_front());
            if (v && !was_full)  model_q.push_back(d);
        end
        if (oc) begin
            m_ovf = 1'b0;
            m_drops = 0;
        end else if (v && was_full) begin
            m_ovf = 1'b1;
            if (m_drops < 16'hFFFF) m_drops++;
        end
        @(negedge axi_aclk);
        $display("cyc v=%0b d=%08h r=%0b fl=%0b oc=%0b -> cnt=%0d ovf=%0b drops=%0d",
                 v, d, r, fl, oc, count_o, overflow_o, drop_cnt_o);
    endtask

    initial begin
        @(negedge axi_aclk);
        @(negedge axi_aclk);
        check_state();                       // reset values while held
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);

        // Fill then drain, with almost-full tracked every cycle.
        for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        check_eq("full_count", 32'(count_o), 32'd8);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_eq("drained_valid", 32'(out_valid_o), 32'd0);

        // Latency: pushing with out_ready high must not bypass.
        check_eq("lat_pre_valid", 32'(out_valid_o), 32'd0);
        cycle(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0);
        check_eq("lat_valid", 32'(out_valid_o), 32'd1);
        check_eq("lat_data",  out_data_o, 32'hA5A5A5A5);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Steady push/pop at count 4, pointers wrap several times.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h100 + DW'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'h200 + DW'(i), 1'b1, 1'b0, 1'b0);
        check_eq("steady_count", 32'(count_o), 32'd4);

        // Overflow: fill, three drops (one with a pop), then clear.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h300 + DW'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hDEAD0001, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hDEAD0002, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);   // fills the slot freed by the pop
        cycle(1'b1, 32'hDEAD0003, 1'b0, 1'b0, 1'b0);
        check_eq("ovf_drops", 32'(drop_cnt_o), 32'd3);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_eq("ovf_cleared", 32'(overflow_o), 32'd0);

        // Flush at count 5 with a drop pending and push/pop in the same cycle.
        cycle(1'b1, 32'hDEAD0004, 1'b0, 1'b0, 1'b0);   // overflow set again
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
        check_eq("flush_count", 32'(count_o), 32'd0);
        check_eq("flush_ovf",   32'(overflow_o), 32'd1);
        cycle(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        check_eq("flush_first", out_data_o, 32'h55);

        // Build count 6 with overflow set, then reset asynchronously mid-cycle.
        for (int i = 0; i < 7; i++) cycle(1'b1, 32'h500 + DW'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hDEAD0005, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_eq("pre_rst_count", 32'(count_o), 32'd6);
        #2;
        axi_aresetn = 1'b0;
        #1;
        model_q.delete();
        m_ovf = 1'b0;
        m_drops = 0;
        check_state();
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        cycle(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Random traffic with varying drain rates to visit full, empty and overflow.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 400; i++) begin
                cycle($urandom_range(0, 99) < 60, $urandom(),
                      $urandom_range(0, 99) < (20 + ph * 25),
                      $urandom_range(0, 99) < 3,
                      $urandom_range(0, 99) < 3);
            end
        end
        check_state();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/spi_slave_axi_rx_fifo.md
Name: spi_slave_axi_rx_fifo

Overview:
Synchronous first-word-fall-through receive buffer in the axi_aclk domain. It sits between the clock-domain-crossing output of the SPI receive path and the rx_data/rx_valid/rx_ready port of the SPI-to-AXI write engine. It absorbs AXI write-latency stalls, so SPI words arriving back-to-back are not lost. It reports occupancy, raises an almost-full warning, and counts words dropped on overflow.

Parameters:
DATA_WIDTH, 32, width of one stored word (matches the write engine's AXI_DATA_WIDTH)
DEPTH, 8, number of entries; power of two, >= 2
AF_THRESH, 2, almost_full asserts when free entries <= AF_THRESH; 0 <= AF_THRESH < DEPTH

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  reset, asynchronous, active-low
flush_i  in  1  synchronous clear of contents (pulse on cs rising or new command)
in_data_i  in  DATA_WIDTH  word from SPI receive CDC
in_valid_i  in  1  in_data_i valid; upstream cannot stall, so it may assert while full
in_ready_o  out  1  space available (informational to upstream)
out_data_o  out  DATA_WIDTH  head word, to write engine rx_data
out_valid_o  out  1  FIFO non-empty, to write engine rx_valid
out_ready_i  in  1  pop, from write engine rx_ready
count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
almost_full_o  out  1  (DEPTH - count_o) <= AF_THRESH
overflow_o  out  1  sticky: a word was dropped
drop_cnt_o  out  16  saturating count of dropped words
ovf_clr_i  in  1  clears overflow_o and drop_cnt_o

Behaviour:
- Reset (async assert, sync deassert by design):
  - pointers = 0, count_o = 0, out_valid_o = 0, in_ready_o = 1, almost_full_o = 0 (for AF_THRESH < DEPTH), overflow_o = 0, drop_cnt_o = 0.
  - out_data_o is don't-care while out_valid_o = 0.
  - Storage array has no reset.
- Storage is a register array; wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- Full/empty come from the registered count: empty = (count == 0), full = (count == DEPTH).
- in_ready_o = !full. out_valid_o = !empty. out_data_o = mem[rd_ptr], combinational from registers.
- FWFT latency: a word pushed in cycle N is visible on out_valid_o/out_data_o in cycle N+1.
- push = in_valid_i & !full; pop = out_ready_i & !empty.
- Pop while empty: ignored, no state change.
- Push and pop in the same cycle (not full, not empty): count unchanged, both pointers advance.
- Push while full: the word is dropped and no storage changes, even if a pop occurs in that cycle. overflow_o is set next cycle and drop_cnt_o increments, saturating at 16'hFFFF.
- Push into empty FIFO with out_ready_i high: no bypass; the word is popped in the following cycle at earliest.
- flush_i has highest priority:
  - Pointers and count go to 0 next cycle.
  - Any push or pop in the same cycle is discarded.
  - A drop check still applies: in_valid_i while full during flush counts as a drop.
  - overflow_o and drop_cnt_o are not affected by flush.
- ovf_clr_i clears overflow_o and drop_cnt_o next cycle. If a drop occurs in the same cycle, the clear wins and the drop is lost from the statistics.
- almost_full_o and count_o are registered, consistent with the post-update state.
- Async reset mid-operation: immediate return to reset values; contents are lost.

Test Plan:
- Fill/drain, DEPTH=8: push 8 words 0x1..0x8 with out_ready_i=0 -> count_o=8, in_ready_o=0, almost_full_o high from count 6. Then pop 8 -> out_data_o yields 0x1..0x8 in order, count_o returns to 0, out_valid_o=0.
- Latency: push 0xA5A5A5A5 into empty FIFO at cycle N -> out_valid_o=1 and out_data_o=0xA5A5A5A5 at N+1, not at N.
- Simultaneous push/pop: hold count=4, drive in_valid_i and out_ready_i for 20 cycles -> count_o stays 4, output order preserved, wr_ptr/rd_ptr wrap past 7.
- Overflow: at full, drive 3 extra pushes (one coinciding with a pop) -> overflow_o=1, drop_cnt_o=3, stored data unchanged. Pulse ovf_clr_i -> both return to 0.
- Flush: with count=5, assert flush_i together with push and pop -> next cycle count_o=0, out_valid_o=0, overflow_o unchanged. A subsequent push of 0x55 emerges first.
- Reset mid-stream: deassert axi_aresetn with count=6 and overflow_o=1 -> all outputs immediately at reset values. After release, normal push/pop resumes from empty.
